// File: rtl/src_ctrl_pkg.sv
// Shared state encoding, opcode table and ALU function mapping for the
// Mini-SRC hardwired control unit.
package src_ctrl_pkg;

  typedef enum logic [3:0] {
    RESET_S = 4'd0,
    T0      = 4'd1,
    T1      = 4'd2,
    T2      = 4'd3,
    T3      = 4'd4,
    T4      = 4'd5,
    T5      = 4'd6,
    T6      = 4'd7,
    HALT_S  = 4'd8,
    FAULT_S = 4'd9
  } state_e;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_OR   = 5'b00010;
  localparam logic [4:0] OP_AND  = 5'b00011;
  localparam logic [4:0] OP_SHR  = 5'b00100;
  localparam logic [4:0] OP_SHRA = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_XOR  = 5'b01001;
  localparam logic [4:0] OP_NAND = 5'b01010;
  localparam logic [4:0] OP_NEG  = 5'b01011;
  localparam logic [4:0] OP_NOT  = 5'b01100;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;

  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_SUB  = 5'b00001;
  localparam logic [4:0] ALU_AND  = 5'b00010;
  localparam logic [4:0] ALU_OR   = 5'b00011;
  localparam logic [4:0] ALU_SHR  = 5'b00100;
  localparam logic [4:0] ALU_SHRA = 5'b00101;
  localparam logic [4:0] ALU_SHL  = 5'b00110;
  localparam logic [4:0] ALU_ROR  = 5'b00111;
  localparam logic [4:0] ALU_ROL  = 5'b01000;
  localparam logic [4:0] ALU_XOR  = 5'b01001;
  localparam logic [4:0] ALU_NAND = 5'b01010;
  localparam logic [4:0] ALU_NEG  = 5'b01011;
  localparam logic [4:0] ALU_NOT  = 5'b01100;
  localparam logic [4:0] ALU_MUL  = 5'b01111;
  localparam logic [4:0] ALU_DIV  = 5'b10000;

  function automatic logic is_muldiv(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  function automatic logic is_legal(input logic [4:0] op);
    return (op <= OP_NOT) || is_muldiv(op);
  endfunction

  // The ALU numbers AND/OR the other way round from the instruction set.
  function automatic logic [4:0] alu_code(input logic [4:0] op);
    case (op)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_OR:   return ALU_OR;
      OP_AND:  return ALU_AND;
      OP_SHR:  return ALU_SHR;
      OP_SHRA: return ALU_SHRA;
      OP_SHL:  return ALU_SHL;
      OP_ROR:  return ALU_ROR;
      OP_ROL:  return ALU_ROL;
      OP_XOR:  return ALU_XOR;
      OP_NAND: return ALU_NAND;
      OP_NEG:  return ALU_NEG;
      OP_NOT:  return ALU_NOT;
      OP_MUL:  return ALU_MUL;
      OP_DIV:  return ALU_DIV;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/alu_sequencer_reg_field_decoder.sv
// Turns a 4-bit register index from an IR field into a one-hot R0-R15 enable.
module reg_field_decoder (
  input  logic [3:0]  idx_i,
  output logic [15:0] onehot_o
);

  assign onehot_o = 16'b1 << idx_i;

endmodule

// File: rtl/alu_sequencer.sv
// Hardwired Mini-SRC control unit: fetch plus R-type / mul / div execution.
//   state   | meaning
//   RESET_S | idle after clear, waits for hold count and run
//   T0..T2  | fetch: PC->MAR, memory read into MDR, MDR->IR
//   T3..T6  | execute (T6 only for mul/div high half)
//   HALT_S  | run low at end of an instruction
//   FAULT_S | illegal opcode, left only through clear
module alu_sequencer
  import src_ctrl_pkg::*;
#(
  parameter int unsigned RESET_PC_HOLD = 0
) (
  input  logic        clock_i,
  input  logic        clear_i,
  input  logic        run_i,
  input  logic        mem_ready_i,
  input  logic [31:0] ir_i,
  output logic [15:0] Rin_o,
  output logic [15:0] Rout_o,
  output logic        HIin_o,
  output logic        LOin_o,
  output logic        Zin_o,
  output logic        Yin_o,
  output logic        PCin_o,
  output logic        MARin_o,
  output logic        MDRin_o,
  output logic        IRin_o,
  output logic        Read_o,
  output logic        IncPC_o,
  output logic        PCout_o,
  output logic        MDRout_o,
  output logic        Zlowout_o,
  output logic        Zhighout_o,
  output logic        HIout_o,
  output logic        LOout_o,
  output logic [4:0]  ALU_Control_o,
  output logic        halted_o,
  output logic        fault_o,
  output logic [3:0]  state_dbg_o
);

  localparam logic [7:0] HOLD_CYCLES = 8'(RESET_PC_HOLD);

  state_e      state_q, state_d;
  logic [7:0]  hold_q, hold_d;
  logic [4:0]  opcode;
  logic [3:0]  ra, rb, rc, rout_idx;
  logic        muldiv, rin_en, rout_en;
  logic [15:0] rin_onehot, rout_onehot;
  logic        unused_ir;

  assign opcode    = ir_i[31:27];
  assign ra        = ir_i[26:23];
  assign rb        = ir_i[22:19];
  assign rc        = ir_i[18:15];
  assign unused_ir = ^ir_i[14:0];
  assign muldiv    = is_muldiv(opcode);

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      RESET_S: begin
        if (hold_q != HOLD_CYCLES) hold_d = hold_q + 8'd1;
        else if (run_i)            state_d = T0;
      end
      T0:      state_d = T1;
      T1:      if (mem_ready_i) state_d = T2;
      T2:      state_d = T3;
      T3:      state_d = is_legal(opcode) ? T4 : FAULT_S;
      T4:      state_d = T5;
      T5: begin
        if (muldiv)     state_d = T6;
        else if (run_i) state_d = T0;
        else            state_d = HALT_S;
      end
      T6:      state_d = run_i ? T0 : HALT_S;
      HALT_S:  if (run_i) state_d = T0;
      FAULT_S: state_d = FAULT_S;
      default: state_d = FAULT_S;
    endcase
  end

  always_ff @(posedge clock_i or posedge clear_i) begin
    if (clear_i) begin
      state_q <= RESET_S;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  // Outputs decode the registered state directly, so clear blanks them at once.
  always_comb begin
    rin_en        = 1'b0;
    rout_en       = 1'b0;
    rout_idx      = rb;
    HIin_o        = 1'b0;
    LOin_o        = 1'b0;
    Zin_o         = 1'b0;
    Yin_o         = 1'b0;
    PCin_o        = 1'b0;
    MARin_o       = 1'b0;
    MDRin_o       = 1'b0;
    IRin_o        = 1'b0;
    Read_o        = 1'b0;
    IncPC_o       = 1'b0;
    PCout_o       = 1'b0;
    MDRout_o      = 1'b0;
    Zlowout_o     = 1'b0;
    Zhighout_o    = 1'b0;
    HIout_o       = 1'b0;
    LOout_o       = 1'b0;
    ALU_Control_o = ALU_ADD;
    case (state_q)
      T0: begin
        PCout_o = 1'b1;
        MARin_o = 1'b1;
        IncPC_o = 1'b1;
        Zin_o   = 1'b1;
      end
      T1: begin
        Zlowout_o = 1'b1;
        Read_o    = 1'b1;
        MDRin_o   = 1'b1;
        PCin_o    = mem_ready_i;
      end
      T2: begin
        MDRout_o = 1'b1;
        IRin_o   = 1'b1;
      end
      T3: if (is_legal(opcode)) begin
        rout_en  = 1'b1;
        rout_idx = muldiv ? ra : rb;
        Yin_o    = 1'b1;
      end
      T4: begin
        rout_en       = 1'b1;
        rout_idx      = muldiv ? rb : rc;
        Zin_o         = 1'b1;
        ALU_Control_o = alu_code(opcode);
      end
      T5: begin
        Zlowout_o = 1'b1;
        LOin_o    = muldiv;
        rin_en    = !muldiv;
      end
      T6: begin
        Zhighout_o = 1'b1;
        HIin_o     = 1'b1;
      end
      default: ;
    endcase
  end

  reg_field_decoder u_rin_dec  (.idx_i(ra),       .onehot_o(rin_onehot));
  reg_field_decoder u_rout_dec (.idx_i(rout_idx), .onehot_o(rout_onehot));

  assign Rin_o       = rin_en  ? rin_onehot  : '0;
  assign Rout_o      = rout_en ? rout_onehot : '0;
  assign halted_o    = (state_q == HALT_S);
  assign fault_o     = (state_q == FAULT_S);
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench: directed and random instructions against a per-cycle strobe model.
module tb_alu_sequencer;

  typedef struct packed {
    logic [15:0] rin;
    logic [15:0] rout;
    logic hiin, loin, zin, yin, pcin, marin, mdrin, irin, read, incpc;
    logic pcout, mdrout, zlowout, zhighout, hiout, loout;
    logic [4:0] alu;
    logic halted, fault;
  } ctl_t;

  logic        clk, clr, run, mem_ready;
  logic [31:0] ir;
  logic [15:0] rin, rout;
  logic hiin, loin, zin, yin, pcin, marin, mdrin, irin, read, incpc;
  logic pcout, mdrout, zlowout, zhighout, hiout, loout;
  logic [4:0]  alu;
  logic        halted, fault;
  logic [3:0]  sdbg;
  ctl_t        obs;
  logic [4:0]  exp_alu [32];
  int          n_cmp = 0;
  int          n_err = 0;

  alu_sequencer dut (
    .clock_i(clk), .clear_i(clr), .run_i(run), .mem_ready_i(mem_ready), .ir_i(ir),
    .Rin_o(rin), .Rout_o(rout), .HIin_o(hiin), .LOin_o(loin), .Zin_o(zin), .Yin_o(yin),
    .PCin_o(pcin), .MARin_o(marin), .MDRin_o(mdrin), .IRin_o(irin), .Read_o(read),
    .IncPC_o(incpc), .PCout_o(pcout), .MDRout_o(mdrout), .Zlowout_o(zlowout),
    .Zhighout_o(zhighout), .HIout_o(hiout), .LOout_o(loout), .ALU_Control_o(alu),
    .halted_o(halted), .fault_o(fault), .state_dbg_o(sdbg)
  );

  assign obs = {rin, rout, hiin, loin, zin, yin, pcin, marin, mdrin, irin, read, incpc,
                pcout, mdrout, zlowout, zhighout, hiout, loout, alu, halted, fault};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input ctl_t exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [3:0] exp);
    n_cmp++;
    assert (sdbg === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, sdbg, exp);
    end
  endtask

  // One instruction from T0 entry; returns at the first cycle after it ends.
  task automatic do_instr(input logic [4:0] op, input logic [3:0] ra, input logic [3:0] rb,
                          input logic [3:0] rc, input int stall, input bit drop_run,
                          input bit clr_t4);
    ctl_t e;
    bit   md, legal;
    md    = (op == 5'd15) || (op == 5'd16);
    legal = (op <= 5'd12) || md;
    ir = {op, ra, rb, rc, 15'($urandom)};
    mem_ready = 1'b0;
    e = '0; e.pcout = 1; e.marin = 1; e.incpc = 1; e.zin = 1;
    @(negedge clk); chk("T0", e); nxt();
    for (int k = 0; k < stall; k++) begin
      mem_ready = 1'b0;
      e = '0; e.zlowout = 1; e.read = 1; e.mdrin = 1;
      @(negedge clk); chk("T1_wait", e); nxt();
    end
    mem_ready = 1'b1;
    e = '0; e.zlowout = 1; e.read = 1; e.mdrin = 1; e.pcin = 1;
    @(negedge clk); chk("T1_ready", e); nxt();
    mem_ready = 1'($urandom);
    e = '0; e.mdrout = 1; e.irin = 1;
    @(negedge clk); chk("T2", e); nxt();
    e = '0;
    if (legal) begin
      e.rout = 16'd1 << (md ? ra : rb);
      e.yin  = 1;
    end
    @(negedge clk); chk("T3", e); nxt();
    if (!legal) return;
    if (drop_run) run = 1'b0;
    e = '0; e.rout = 16'd1 << (md ? rb : rc); e.zin = 1; e.alu = exp_alu[op];
    @(negedge clk); chk("T4", e);
    if (clr_t4) begin
      #2 clr = 1'b1;
      #1;
      chk("clear_async", '0);
      chk_state("clear_state", 4'd0);
      return;
    end
    nxt();
    e = '0; e.zlowout = 1;
    if (md) e.loin = 1;
    else    e.rin  = 16'd1 << ra;
    @(negedge clk); chk("T5", e); nxt();
    if (md) begin
      e = '0; e.zhighout = 1; e.hiin = 1;
      @(negedge clk); chk("T6", e); nxt();
    end
  endtask

  task automatic release_clear();
    nxt();
    clr = 1'b0;
    nxt();
  endtask

  task automatic fault_phase(input int cycles);
    ctl_t e;
    e = '0; e.fault = 1;
    for (int k = 0; k < cycles; k++) begin
      mem_ready = 1'($urandom);
      run       = 1'($urandom);
      @(negedge clk); chk("fault_hold", e); nxt();
    end
    run = 1'b1;
    clr = 1'b1;
    #1;
    chk("fault_clear", '0);
    chk_state("fault_clear_state", 4'd0);
    release_clear();
  endtask

  initial begin
    ctl_t       e;
    int         r;
    logic [4:0] op;

    for (int i = 0; i < 32; i++) exp_alu[i] = 5'(i);
    exp_alu[2] = 5'd3;
    exp_alu[3] = 5'd2;

    clr = 1'b1; run = 1'b1; mem_ready = 1'b0; ir = '0;
    @(negedge clk);
    chk("reset_outputs", '0);
    chk_state("reset_state", 4'd0);
    release_clear();

    do_instr(5'd2, 4'd2, 4'd5, 4'd6, 0, 0, 0);
    do_instr(5'd2, 4'd2, 4'd5, 4'd6, 3, 0, 0);
    do_instr(5'd15, 4'd3, 4'd4, 4'($urandom), 0, 0, 0);
    do_instr(5'd16, 4'd15, 4'd0, 4'($urandom), 2, 0, 0);
    do_instr(5'd0, 4'd0, 4'd15, 4'd1, 1, 0, 0);

    for (int i = 0; i < 40; i++) begin
      r  = int'($urandom_range(0, 14));
      op = (r <= 12) ? 5'(r) : ((r == 13) ? 5'd15 : 5'd16);
      do_instr(op, 4'($urandom), 4'($urandom), 4'($urandom), int'($urandom_range(0, 3)), 0, 0);
    end

    do_instr(5'd31, 4'd1, 4'd2, 4'd3, 0, 0, 0);
    fault_phase(10);
    for (int i = 0; i < 3; i++) begin
      r  = int'($urandom_range(0, 16));
      op = (r < 2) ? 5'(13 + r) : 5'(15 + r);
      do_instr(op, 4'($urandom), 4'($urandom), 4'($urandom), int'($urandom_range(0, 2)), 0, 0);
      fault_phase(3);
    end

    for (int i = 0; i < 2; i++) begin
      op = (i == 0) ? 5'd1 : 5'd15;
      do_instr(op, 4'd7, 4'd8, 4'd9, 1, 1, 0);
      e = '0; e.halted = 1;
      for (int k = 0; k < 3; k++) begin
        mem_ready = 1'($urandom);
        @(negedge clk); chk("halted", e); nxt();
      end
      run = 1'b1;
      nxt();
      do_instr(5'd4, 4'd1, 4'd2, 4'd3, 0, 0, 0);
    end

    do_instr(5'd6, 4'd10, 4'd11, 4'd12, 0, 0, 1);
    release_clear();
    do_instr(5'd3, 4'd14, 4'd13, 4'd12, 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Hardwired control unit that sequences the Mini-SRC datapath through instruction fetch and execution of register-register ALU, multiply and divide instructions. It replaces the hand-driven control strobes used in phase-1 benches: it watches the datapath IR and a memory ready flag, and drives every register in/out enable, the IncPC strobe and the ALU function code. It sits beside `datapath`, and its output bundle connects one-to-one to the datapath control ports.

## Interface
- `RESET_PC_HOLD`, default 0: number of extra idle cycles in RESET_S after `clear` deasserts before the first fetch.
- `clock`  in  1  system clock; all state changes on its rising edge.
- `clear`  in  1  asynchronous, active-high reset.
- `run`  in  1  level; 1 = keep fetching, 0 = halt after the current instruction.
- `mem_ready`  in  1  memory read data valid; sampled in T1.
- `ir`  in  32  datapath IR contents. Fields: opcode [31:27], ra [26:23], rb [22:19], rc [18:15].
- `Rin`, `Rout`  out  16 each  one-hot R0–R15 in/out enables.
- `HIin`, `LOin`, `Zin`, `Yin`, `PCin`, `MARin`, `MDRin`, `IRin`, `Read`, `IncPC`  out  1 each  datapath load/strobe enables.
- `PCout`, `MDRout`, `Zlowout`, `Zhighout`, `HIout`, `LOout`  out  1 each  bus drive enables.
- `ALU_Control`  out  5  ALU function code.
- `halted`  out  1  high in HALT_S.
- `fault`  out  1  high in FAULT_S.
- `state_dbg`  out  4  current state encoding.

## Operation
- **States and transitions:**
  - RESET_S → T0 when `run`=1 and the hold count has elapsed.
  - T0 → T1 → T2 → T3 → T4 → T5.
  - At T5: go to T6 if the opcode is mul/div; otherwise go to T0 if `run`=1, else HALT_S.
  - T6 → T0 if `run`=1, else HALT_S.
  - HALT_S → T0 when `run`=1.
  - FAULT_S is exited only by `clear`.
- **T0:** PCout, MARin, IncPC, Zin; ALU_Control=ADD (00000).
- **T1:** Zlowout, PCin, Read, MDRin.
  - Stays in T1 while `mem_ready`=0.
  - PCin is asserted only in the cycle where `mem_ready`=1, so PC is loaded exactly once.
- **T2:** MDRout, IRin.
- **T3 decode:** the opcode is checked against the package table.
  - Illegal opcode → FAULT_S next cycle; no T3 strobes.
  - R-type: Rout[rb], Yin.
  - mul/div: Rout[ra], Yin.
- **T4:**
  - R-type: Rout[rc], Zin, ALU_Control=alu_code(opcode).
  - mul/div: Rout[rb], Zin, ALU_Control=alu_code(opcode).
- **T5:**
  - R-type: Zlowout, Rin[ra].
  - mul/div: Zlowout, LOin.
- **T6 (mul/div only):** Zhighout, HIin.
- All unlisted outputs are 0 in every state. At most one bus-drive enable is high in any cycle.
- Field decode: register index n asserts bit n of `Rin`/`Rout`.
- **Reset:** asynchronous `clear` forces RESET_S, zeroes the hold counter, and sets every output to 0, including `halted`, `fault` and `state_dbg`=0. This applies immediately, including mid-instruction.

## Timing
- Outputs are Moore-style: combinational decode of the registered state and the `ir` input. `ir` is stable from T3 onward because IR loads at the end of T2.
- Latency from T0 entry to the register write edge:
  - R-type: 6 cycles when `mem_ready` is high in the first T1 cycle.
  - mul/div: 7 cycles.
  - Each cycle of `mem_ready`=0 in T1 adds 1 cycle.
- `run` is sampled only at the end of T5/T6 and in RESET_S/HALT_S. Dropping it mid-instruction does not abort the instruction.
- If `clear` and `mem_ready` are both high, `clear` wins.

## Structure
- Package `src_ctrl_pkg` holds:
  - state enum: RESET_S, T0–T6, HALT_S, FAULT_S, with a 4-bit encoding;
  - opcode constants: R-type 00000–01100, mul 01111, div 10000; everything else is illegal;
  - function `alu_code(opcode)`, e.g. or 00010 → 00011, add 00000 → 00000;
  - function `is_legal`.
- One sub-module, `reg_field_decoder`: converts a 4-bit index to a 16-bit one-hot value. It is instantiated twice, for Rin and Rout.

## Test plan
- `ir`=0x112B0000 (or R2,R5,R6), `mem_ready`=1, R5=0x34, R6=0x45 → expect:
  - T3: Rout=0x0020;
  - T4: Rout=0x0040, ALU_Control=00011;
  - T5: Zlowout=1, Rin=0x0004;
  - R2=0x75 after T5.
- `mem_ready` held 0 for 3 cycles in T1 → T1 lasts 4 cycles and PCin pulses for exactly 1 cycle; total latency is 9 cycles.
- mul opcode 01111, ra=3, rb=4 → expect:
  - T5: Zlowout+LOin;
  - T6: Zhighout+HIin;
  - `Rin` stays 0 throughout.
- Opcode 11111 → FAULT_S after T3, `fault`=1, all strobes 0 for 10 cycles; `clear` returns the unit to RESET_S.
- `run` dropped during T4 → the instruction completes at T5, then HALT_S with `halted`=1. Raising `run` again resumes at T0.
- `clear` asserted mid-T4 → all outputs 0 asynchronously before the next edge and `state_dbg`=0. After release, the next fetch starts at T0.
